// File: rtl/sd_req_pkg.sv
// Shared types and helpers for the SD request arbiter.
package sd_req_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER
  } state_e;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
module rr_pick #(
  parameter int NCH = 3,
  parameter int GW  = 2
) (
  input  logic [NCH-1:0] req_i,
  input  logic [GW-1:0]  last_i,
  output logic [GW-1:0]  idx_o,
  output logic           valid_o
);

  always_comb begin
    int unsigned c;
    c       = 0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      c = (32'(last_i) + k) % NCH;
      if (!valid_o && req_i[c]) begin
        valid_o = 1'b1;
        idx_o   = GW'(c);
      end
    end
  end

endmodule

// File: rtl/sd_req_arbiter.sv
// Arbitrates per-channel block read/write requests onto a single host SD bridge,
// with round-robin fairness, write-before-read per channel and a watchdog timeout.
module sd_req_arbiter
  import sd_req_pkg::*;
#(
  parameter  int NCH   = 3,
  parameter  int LBA_W = 32,
  parameter  int TMO_W = 24,
  localparam int GW    = grant_w(NCH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 abort,
  input  logic [NCH-1:0]       req_rd,
  input  logic [NCH-1:0]       req_wr,
  input  logic [NCH*LBA_W-1:0] req_lba,
  output logic [NCH-1:0]       sd_rd,
  output logic [NCH-1:0]       sd_wr,
  output logic [LBA_W-1:0]     sd_lba,
  input  logic [NCH-1:0]       sd_ack,
  output logic [GW-1:0]        grant,
  output logic                 cpu_wait,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       done,
  output logic [NCH-1:0]       err
);

  // Compared against the pre-increment count so the timeout lands exactly
  // 2^TMO_W-1 cycles after entering REQ or XFER.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((64'd1 << TMO_W) - 64'd2);

  state_e           state_q, state_d;
  logic [NCH-1:0]   rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [NCH-1:0]   sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic [NCH-1:0]   done_q, done_d, err_q, err_d;
  logic [NCH-1:0]   ack_q;
  logic [GW-1:0]    grant_q, grant_d, last_q, last_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             is_wr_q, is_wr_d;

  logic [NCH-1:0]   rd_eff, wr_eff, pend_any, gnt_oh, pick_oh;
  logic [GW-1:0]    pick_idx;
  logic             pick_vld;
  logic             ack_rise, ack_fall, tmo;

  assign rd_eff   = rd_pend_q | req_rd;
  assign wr_eff   = wr_pend_q | req_wr;
  assign pend_any = rd_eff | wr_eff;
  assign gnt_oh   = NCH'(1) << grant_q;
  assign pick_oh  = NCH'(1) << pick_idx;
  assign ack_rise = sd_ack[grant_q] & ~ack_q[grant_q];
  assign ack_fall = ~sd_ack[grant_q] & ack_q[grant_q];
  assign tmo      = (cnt_q == TMO_LAST);

  rr_pick #(
    .NCH (NCH),
    .GW  (GW)
  ) u_pick (
    .req_i   (pend_any),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    rd_pend_d = rd_eff;
    wr_pend_d = wr_eff;
    grant_d   = grant_q;
    last_d    = last_q;
    lba_d     = lba_q;
    is_wr_d   = is_wr_q;
    sd_rd_d   = sd_rd_q;
    sd_wr_d   = sd_wr_q;
    cnt_d     = cnt_q + 1'b1;
    done_d    = '0;
    err_d     = '0;

    if (abort) begin
      state_d   = IDLE;
      rd_pend_d = '0;
      wr_pend_d = '0;
      sd_rd_d   = '0;
      sd_wr_d   = '0;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (pick_vld) begin
            grant_d = pick_idx;
            lba_d   = req_lba[int'(pick_idx)*LBA_W +: LBA_W];
            is_wr_d = |(wr_eff & pick_oh);
            if (is_wr_d) sd_wr_d = pick_oh;
            else         sd_rd_d = pick_oh;
            state_d = REQ;
          end
        end
        REQ: begin
          if (ack_rise || tmo) begin
            sd_rd_d = '0;
            sd_wr_d = '0;
            // Only the served direction clears; a same-cycle new request re-arms it.
            if (is_wr_q) wr_pend_d = (wr_pend_q & ~gnt_oh) | req_wr;
            else         rd_pend_d = (rd_pend_q & ~gnt_oh) | req_rd;
            if (ack_rise) begin
              state_d = XFER;
              cnt_d   = '0;
            end else begin
              err_d   = gnt_oh;
              last_d  = grant_q;
              state_d = IDLE;
            end
          end
        end
        XFER: begin
          if (ack_fall || tmo) begin
            if (ack_fall) done_d = gnt_oh;
            else          err_d  = gnt_oh;
            last_d  = grant_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rd_pend_q <= '0;
      wr_pend_q <= '0;
      grant_q   <= '0;
      last_q    <= GW'(NCH - 1);
      lba_q     <= '0;
      is_wr_q   <= 1'b0;
      sd_rd_q   <= '0;
      sd_wr_q   <= '0;
      cnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      wr_pend_q <= wr_pend_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      lba_q     <= lba_d;
      is_wr_q   <= is_wr_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ack_q     <= sd_ack;
    end
  end

  assign sd_rd    = sd_rd_q;
  assign sd_wr    = sd_wr_q;
  assign sd_lba   = lba_q;
  assign grant    = grant_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_wait = (state_q != IDLE) | (|rd_pend_q) | (|wr_pend_q);
  assign busy     = rd_pend_q | wr_pend_q | ((state_q != IDLE) ? gnt_oh : '0);

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Self-checking bench for sd_req_arbiter: directed vector table, corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_sd_req_arbiter;

  localparam int NCH   = 3;
  localparam int LBA_W = 32;
  localparam int TMO_W = 4;
  localparam int TMO   = 15;

  logic                 clk = 1'b0;
  logic                 reset_n, abort;
  logic [NCH-1:0]       req_rd, req_wr, sd_ack;
  logic [NCH*LBA_W-1:0] req_lba;
  logic [NCH-1:0]       sd_rd, sd_wr, busy, done, err;
  logic [LBA_W-1:0]     sd_lba;
  logic [1:0]           grant;
  logic                 cpu_wait;

  always #5 clk = ~clk;

  sd_req_arbiter #(
    .NCH   (NCH),
    .LBA_W (LBA_W),
    .TMO_W (TMO_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .abort    (abort),
    .req_rd   (req_rd),
    .req_wr   (req_wr),
    .req_lba  (req_lba),
    .sd_rd    (sd_rd),
    .sd_wr    (sd_wr),
    .sd_lba   (sd_lba),
    .sd_ack   (sd_ack),
    .grant    (grant),
    .cpu_wait (cpu_wait),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  rd, wr, ack;
    logic [95:0] lba;
    logic [2:0]  e_rd, e_wr;
    logic [1:0]  e_gnt;
    logic [31:0] e_lba;
    logic        e_cpu;
    logic [2:0]  e_busy, e_done;
  } vec_t;

  vec_t tbl[19];

  // Reference model: pending sets, one transaction record with an age counter.
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_DATA = 2;
  logic [2:0]  m_rdp, m_wrp, m_prev, m_done, m_err;
  int          m_last, m_phase, m_ch, m_age;
  bit          m_is_wr;
  logic [31:0] m_lba;

  task automatic model_init();
    m_rdp = '0; m_wrp = '0; m_prev = '0; m_done = '0; m_err = '0;
    m_last = NCH - 1; m_phase = PH_IDLE; m_ch = 0; m_age = 0; m_is_wr = 0; m_lba = '0;
  endtask

  task automatic model_finish_served();
    if (m_is_wr) m_wrp[m_ch] = 1'b0;
    else         m_rdp[m_ch] = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] rd, input logic [2:0] wr, input logic [2:0] ack,
                            input logic ab, input logic [95:0] lba);
    int  c;
    bit  found;
    m_done = '0;
    m_err  = '0;
    if (ab) begin
      m_rdp = '0; m_wrp = '0; m_phase = PH_IDLE;
    end else begin
      case (m_phase)
        PH_IDLE: begin
          found = 0;
          for (int k = 1; k <= NCH; k++) begin
            c = (m_last + k) % NCH;
            if (!found && (m_rdp[c] | m_wrp[c] | rd[c] | wr[c])) begin
              found = 1; m_ch = c;
            end
          end
          if (found) begin
            m_is_wr = m_wrp[m_ch] | wr[m_ch];
            m_lba   = lba[m_ch*32 +: 32];
            m_phase = PH_WAIT;
            m_age   = 0;
          end
        end
        PH_WAIT: begin
          m_age++;
          if (ack[m_ch] && !m_prev[m_ch]) begin
            model_finish_served(); m_phase = PH_DATA; m_age = 0;
          end else if (m_age == TMO) begin
            model_finish_served(); m_err[m_ch] = 1'b1; m_last = m_ch; m_phase = PH_IDLE;
          end
        end
        default: begin
          m_age++;
          if (!ack[m_ch] && m_prev[m_ch]) begin
            m_done[m_ch] = 1'b1; m_last = m_ch; m_phase = PH_IDLE;
          end else if (m_age == TMO) begin
            m_err[m_ch] = 1'b1; m_last = m_ch; m_phase = PH_IDLE;
          end
        end
      endcase
      m_rdp = m_rdp | rd;
      m_wrp = m_wrp | wr;
    end
    m_prev = ack;
  endtask

  function automatic logic [63:0] model_out();
    logic [2:0] oh, srd, swr, bsy;
    logic       cpu;
    oh  = 3'b001 << m_ch;
    srd = (m_phase == PH_WAIT && !m_is_wr) ? oh : 3'b000;
    swr = (m_phase == PH_WAIT &&  m_is_wr) ? oh : 3'b000;
    bsy = m_rdp | m_wrp | ((m_phase != PH_IDLE) ? oh : 3'b000);
    cpu = (m_phase != PH_IDLE) || (m_rdp != 0) || (m_wrp != 0);
    return {14'd0, srd, swr, 2'(m_ch), cpu, bsy, m_done, m_err, m_lba};
  endfunction

  function automatic logic [63:0] dut_out();
    return {14'd0, sd_rd, sd_wr, grant, cpu_wait, busy, done, err, sd_lba};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] l37, l36, l38;
    int          lat;
    bit          seen;

    l37 = {32'h300, 32'h0, 32'h100};
    l36 = {32'h0, 32'h1234, 32'h0};
    l38 = {32'h0, 32'hABCD, 32'h0};
    //          rd      wr      ack     lba  e_rd    e_wr    gnt   e_lba          cpu   busy    done
    tbl[0]  = '{3'b101, 3'b000, 3'b000, l37, 3'b001, 3'b000, 2'd0, 32'h100,  1'b1, 3'b101, 3'b000};
    tbl[1]  = '{3'b000, 3'b000, 3'b001, l37, 3'b000, 3'b000, 2'd0, 32'h100,  1'b1, 3'b101, 3'b000};
    tbl[2]  = '{3'b000, 3'b000, 3'b000, l37, 3'b000, 3'b000, 2'd0, 32'h100,  1'b1, 3'b100, 3'b001};
    tbl[3]  = '{3'b000, 3'b000, 3'b000, l37, 3'b100, 3'b000, 2'd2, 32'h300,  1'b1, 3'b100, 3'b000};
    tbl[4]  = '{3'b000, 3'b000, 3'b100, l37, 3'b000, 3'b000, 2'd2, 32'h300,  1'b1, 3'b100, 3'b000};
    tbl[5]  = '{3'b000, 3'b000, 3'b000, l37, 3'b000, 3'b000, 2'd2, 32'h300,  1'b0, 3'b000, 3'b100};
    tbl[6]  = '{3'b010, 3'b000, 3'b000, l36, 3'b010, 3'b000, 2'd1, 32'h1234, 1'b1, 3'b010, 3'b000};
    tbl[7]  = '{3'b000, 3'b000, 3'b010, l36, 3'b000, 3'b000, 2'd1, 32'h1234, 1'b1, 3'b010, 3'b000};
    tbl[8]  = '{3'b000, 3'b000, 3'b010, l36, 3'b000, 3'b000, 2'd1, 32'h1234, 1'b1, 3'b010, 3'b000};
    tbl[9]  = '{3'b000, 3'b000, 3'b010, l36, 3'b000, 3'b000, 2'd1, 32'h1234, 1'b1, 3'b010, 3'b000};
    tbl[10] = '{3'b000, 3'b000, 3'b000, l36, 3'b000, 3'b000, 2'd1, 32'h1234, 1'b0, 3'b000, 3'b010};
    tbl[11] = '{3'b000, 3'b000, 3'b000, l36, 3'b000, 3'b000, 2'd1, 32'h1234, 1'b0, 3'b000, 3'b000};
    tbl[12] = '{3'b010, 3'b010, 3'b000, l38, 3'b000, 3'b010, 2'd1, 32'hABCD, 1'b1, 3'b010, 3'b000};
    tbl[13] = '{3'b000, 3'b000, 3'b010, l38, 3'b000, 3'b000, 2'd1, 32'hABCD, 1'b1, 3'b010, 3'b000};
    tbl[14] = '{3'b000, 3'b000, 3'b000, l38, 3'b000, 3'b000, 2'd1, 32'hABCD, 1'b1, 3'b010, 3'b010};
    tbl[15] = '{3'b000, 3'b000, 3'b000, l38, 3'b010, 3'b000, 2'd1, 32'hABCD, 1'b1, 3'b010, 3'b000};
    tbl[16] = '{3'b000, 3'b000, 3'b010, l38, 3'b000, 3'b000, 2'd1, 32'hABCD, 1'b1, 3'b010, 3'b000};
    tbl[17] = '{3'b000, 3'b000, 3'b000, l38, 3'b000, 3'b000, 2'd1, 32'hABCD, 1'b0, 3'b000, 3'b010};
    tbl[18] = '{3'b000, 3'b000, 3'b000, l38, 3'b000, 3'b000, 2'd1, 32'hABCD, 1'b0, 3'b000, 3'b000};

    reset_n = 1'b0; abort = 1'b0; req_rd = '0; req_wr = '0; sd_ack = '0; req_lba = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", dut_out(), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      req_rd = tbl[i].rd; req_wr = tbl[i].wr; sd_ack = tbl[i].ack; req_lba = tbl[i].lba;
      step();
      chk($sformatf("tbl%0d_strobes", i), {sd_wr, sd_rd}, {tbl[i].e_wr, tbl[i].e_rd});
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].e_gnt);
      chk($sformatf("tbl%0d_lba", i), sd_lba, tbl[i].e_lba);
      chk($sformatf("tbl%0d_cpu_busy", i), {cpu_wait, busy}, {tbl[i].e_cpu, tbl[i].e_busy});
      chk($sformatf("tbl%0d_done_err", i), {err, done}, {3'b000, tbl[i].e_done});
    end

    // Timeout with no acknowledge.
    req_wr = 3'b100; req_lba = {32'h55, 64'h0};
    step();
    req_wr = '0;
    chk("tmo_strobe", {sd_wr, sd_rd}, {3'b100, 3'b000});
    chk("tmo_grant", grant, 2'd2);
    lat = 0; seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      step();
      if (i == 14) chk("tmo_strobe_held", sd_wr, 3'b100);
      if (err != 0) begin seen = 1; lat = i; end
    end
    chk("tmo_latency", lat, TMO);
    chk("tmo_err", err, 3'b100);
    chk("tmo_after", {sd_wr, sd_rd, cpu_wait, busy}, 10'd0);
    step();
    chk("tmo_err_pulse", err, 3'b000);

    // Abort during XFER with another channel pending; late ack fall ignored.
    req_rd = 3'b010; req_lba = {32'h0, 32'h77, 32'h0};
    step();
    chk("abt_strobe", {sd_rd, grant}, {3'b010, 2'd1});
    req_rd = 3'b001; sd_ack = 3'b010;
    step();
    req_rd = '0;
    chk("abt_xfer", {sd_rd, cpu_wait, busy}, {3'b000, 1'b1, 3'b011});
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abt_cleared", {sd_rd, sd_wr, cpu_wait, busy, done}, 13'd0);
    sd_ack = '0;
    step();
    chk("abt_late_fall", {done, busy, sd_rd}, 9'd0);
    step();
    chk("abt_idle", {sd_rd, sd_wr, cpu_wait}, 7'd0);

    // Asynchronous reset in the middle of REQ.
    req_rd = 3'b100; req_lba = {32'h99, 64'h0};
    step();
    req_rd = '0;
    chk("rst_pre", {sd_rd, grant}, {3'b100, 2'd2});
    #2 reset_n = 1'b0;
    #1 chk("rst_async", dut_out(), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    req_rd = 3'b001; req_lba = {64'h0, 32'h42};
    step();
    req_rd = '0;
    chk("rst_serve", {sd_rd, grant, sd_lba}, {3'b001, 2'd0, 32'h42});
    sd_ack = 3'b001;
    step();
    sd_ack = '0;
    step();
    chk("rst_done", {done, cpu_wait}, {3'b001, 1'b0});

    // Randomized traffic against the reference model.
    reset_n = 1'b0; req_rd = '0; req_wr = '0; sd_ack = '0; abort = 1'b0;
    step();
    reset_n = 1'b1;
    model_init();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rand_outputs", dut_out(), model_out());
      for (int c = 0; c < NCH; c++) begin
        req_rd[c] = ($urandom_range(0, 9) == 0);
        req_wr[c] = ($urandom_range(0, 11) == 0);
        if (((cyc / 200) % 3 != 2) && ($urandom_range(0, 3) == 0)) sd_ack[c] = ~sd_ack[c];
      end
      req_lba = {$urandom(), $urandom(), $urandom()};
      abort   = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      model_step(req_rd, req_wr, sd_ack, abort, req_lba);
      @(negedge clk);
    end
    chk("rand_final", dut_out(), model_out());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_req_arbiter.md
SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 Parameter NCH, default 3: number of block-device channels (floppy 1, HDD, floppy 2); legal range 1..8.
REQ-002 Parameter LBA_W, default 32: LBA width.
REQ-003 Parameter TMO_W, default 24: timeout counter width; timeout is 2^TMO_W-1 cycles.
REQ-004 clk  in  1  sole clock; all state is on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 abort  in  1  synchronous drive reset; drops all pending and in-flight requests.
REQ-007 req_rd  in  NCH  per-channel read request; single-cycle pulse or level.
REQ-008 req_wr  in  NCH  per-channel write request; single-cycle pulse or level.
REQ-009 req_lba  in  NCH*LBA_W  per-channel LBA; channel i occupies bits [i*LBA_W +: LBA_W].
REQ-010 sd_rd  out  NCH  read strobe to the host SD bridge; at most one bit set.
REQ-011 sd_wr  out  NCH  write strobe to the host SD bridge; at most one bit set.
REQ-012 sd_lba  out  LBA_W  LBA of the granted channel, registered at grant.
REQ-013 sd_ack  in  NCH  bridge acknowledge; high for the whole buffer transfer.
REQ-014 grant  out  $clog2(NCH) (min 1)  index of the channel in service.
REQ-015 cpu_wait  out  1  CPU stall request.
REQ-016 busy  out  NCH  channel has a pending or in-flight request.
REQ-017 done  out  NCH  one-cycle pulse on normal completion.
REQ-018 err  out  NCH  one-cycle pulse on timeout.

Function
REQ-019 Each channel SHALL hold independent rd_pend and wr_pend bits, set by req_rd/req_wr, ORed every cycle.
REQ-020 The state machine SHALL have three states: IDLE, REQ, XFER.
REQ-021 In IDLE, if any channel is pending, the block SHALL pick one channel round-robin starting at (last_grant+1) mod NCH.
  - On that pick it SHALL register grant and sd_lba.
  - It SHALL assert exactly one strobe and enter REQ.
REQ-022 When a channel has both wr_pend and rd_pend, the write SHALL be issued first; the read SHALL stay pending and compete in a later arbitration.
REQ-023 In REQ, on a sd_ack[grant] rising edge, the block SHALL:
  - drop the strobe;
  - clear the pending bit being served;
  - enter XFER.
REQ-024 A new request on a channel after its bit clears SHALL set the bit again and be served in a later transaction.
REQ-025 In XFER, on a sd_ack[grant] falling edge, the block SHALL pulse done[grant], update last_grant and return to IDLE.
REQ-026 Edge detection SHALL use a registered copy of sd_ack.
  - Minimum latency from a pending bit to a strobe is 1 cycle.
  - A request cycle is followed by at least one IDLE cycle.
REQ-027 sd_ack edges on non-granted channels SHALL be ignored.
REQ-028 A TMO_W-bit counter SHALL clear on entry to REQ or XFER and increment while in either state.
  - On all-ones it SHALL pulse err[grant], drop the strobe and clear the served pending bit.
  - It SHALL then update last_grant and return to IDLE.
REQ-029 cpu_wait SHALL be high whenever the state is not IDLE or any pending bit is set, and low otherwise.
REQ-030 busy[i] SHALL equal rd_pend[i] | wr_pend[i] | (state!=IDLE & grant==i).
REQ-031 abort SHALL force IDLE and clear all pending bits, strobes, the counter and cpu_wait.
  - It SHALL have priority over requests arriving in the same cycle.

Reset
REQ-032 On reset_n low, all outputs SHALL be 0 and state SHALL be IDLE.
  - last_grant SHALL be NCH-1, so that channel 0 wins first.
  - All pending bits and the counter SHALL be 0.
REQ-033 Reset SHALL be released with no further synchronisation inside the block; the integrator supplies a deasserted-synchronous reset_n.

Structure
REQ-034 Package sd_req_pkg SHALL hold the state enum (IDLE/REQ/XFER) and the function computing the grant width.
REQ-035 Round-robin selection SHALL be the sub-module rr_pick (NCH-bit request vector and last index in; index and valid out), purely combinational.

Verification
REQ-036 req_rd[1] pulse, lba 0x1234 -> next cycle sd_rd=010, sd_lba=0x1234, cpu_wait=1; ack high 3 cycles -> done[1] pulse, cpu_wait=0.
REQ-037 req_rd[0], req_rd[2] same cycle after reset -> channel 0 served first, channel 2 second; both done pulses fire, in that order.
REQ-038 req_rd[1] and req_wr[1] together -> sd_wr[1] transaction, then sd_rd[1] transaction; busy[1] low only after the second done.
REQ-039 TMO_W=4, req_wr[2], no ack -> err[2] pulse 15 cycles after REQ entry; sd_wr=0, IDLE, cpu_wait=0.
REQ-040 abort during XFER with req_rd[0] pending -> next cycle IDLE, all strobes and busy at 0, no done pulse; a late ack fall is ignored.
REQ-041 reset_n low mid-REQ -> outputs 0 asynchronously; after release, req_rd[0] is served normally.
